sauria_eoc_monitor: RTL
=======================

Name: sauria_eoc_monitor

Overview:
Synthesizable multi-channel end-of-computation monitor for the SAURIA SoC. It generalises the single-channel "wait for EOC, fetch exit code" flow to NumChannels independent completion mailboxes, one per hart, accelerator or DMA. It adds a heartbeat-reloaded watchdog and aggregates all channels into one verdict. It sits on the SoC register side, so sim benches and silicon tests read a single done/exit code.

Parameters:
NumChannels, 4, number of completion mailboxes (1..32)
CodeWidth, 32, width of each mailbox write word; exit code is the upper CodeWidth-1 bits
TimeoutWidth, 32, width of the watchdog counter
IdxWidth, $clog2(NumChannels) (min 1), derived; width of the channel index

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous, active-high reset
arm_i  in  1  single-cycle start pulse
chan_en_i  in  NumChannels  channels to wait on; sampled at arm
timeout_cycles_i  in  TimeoutWidth  watchdog reload value; 0 = watchdog disabled; sampled at arm
wr_valid_i  in  NumChannels  per-channel mailbox write valid
wr_data_i  in  NumChannels*CodeWidth  per-channel write word; bit0 = EOC flag
wr_ready_o  out  NumChannels  per-channel ready
busy_o  out  1  high in RUN
done_o  out  1  high in DONE (level)
timeout_o  out  1  verdict was a watchdog expiry
exit_code_o  out  CodeWidth  aggregated exit code
fail_idx_o  out  IdxWidth  lowest channel with a nonzero code
chan_done_o  out  NumChannels  per-channel EOC seen

Behaviour:
- Reset: state IDLE; every output is 0; all channel regs, the enable mask and the counter are cleared. Reset in any state, including mid-RUN, aborts without a verdict.
- States: IDLE, RUN, DONE.
- IDLE, arm_i=1 -> RUN next cycle. On arm: latch chan_en_i into en_q, load counter with timeout_cycles_i, clear chan_done/codes/timeout.
- If en_q is all zero at arm: go to DONE next cycle instead of RUN, with exit_code_o=0 and timeout_o=0.
- RUN, ready rule: wr_ready_o[i] = en_q[i] & ~chan_done[i]. Ready is 0 outside RUN. A transfer occurs on valid & ready.
- RUN, transfer with data bit0=1: chan_done[i]<=1; code[i] <= data >> 1 (zero-extended to CodeWidth); later writes on that channel are blocked because ready drops.
- RUN, transfer with bit0=0: heartbeat. Data is discarded, and the counter reloads with the latched timeout value in the same edge.
- Several channels may transfer in the same cycle; all are accepted.
- Watchdog: when enabled, the counter decrements each RUN cycle without a heartbeat. Expiry happens when the counter is 1 and is being decremented. On expiry: DONE next cycle with timeout_o=1 and exit_code_o all ones.
- Completion: DONE is entered the cycle after the edge at which chan_done covers en_q, so done_o rises 1 cycle after the last EOC handshake.
- Completion and expiry in the same cycle: completion wins, timeout_o=0.
- Verdict: exit_code_o = code of the lowest-index enabled channel with code != 0, else 0. fail_idx_o = that index, else 0.
- Verdict registers: exit_code_o, fail_idx_o and timeout_o are registered, and hold stable for all of DONE.
- RUN, arm_i: ignored.
- DONE, arm_i=1: rearm exactly as from IDLE. Outputs clear on the next edge.
- chan_done_o reflects the live per-channel flags in RUN and DONE.

Decomposition:
- sauria_eoc_pkg: state enum eoc_state_e {IDLE,RUN,DONE}; constant EocTimeoutCode (all ones); a function that extracts the code from a mailbox word.
- One sub-module, sauria_eoc_watchdog: counter with load/reload/enable/expire, parametrised by TimeoutWidth.
- Top module: FSM, per-channel regs, and a lowest-index priority selector.

Test Plan:
1. NumChannels=4, en=4'b1111, timeout=0. EOC words 0x1,0x1,0x1,0x1 on different cycles -> done_o 1 cycle after the last handshake; exit_code_o=0, timeout_o=0, chan_done_o=4'hF.
2. en=4'b0110. ch1 writes 0x7, ch2 writes 0x1 in the same cycle -> both accepted; ready drops; done_o next cycle; exit_code_o=3, fail_idx_o=1; ch0/ch3 writes never accepted.
3. en=4'b0001, timeout=10, no writes -> done_o with timeout_o=1 and exit_code_o=0xFFFFFFFF, 11 cycles after arm (1 to enter RUN + 10 countdown).
4. timeout=5; ch0 heartbeat (0x0) every 4 cycles for 40 cycles, then EOC 0x1 -> no timeout; exit_code_o=0.
5. timeout=3; final EOC lands on the expiry cycle -> timeout_o=0, normal verdict.
6. Reset mid-RUN -> all outputs 0 next edge; arm in DONE -> clean rerun; arm with en=0 -> done_o after 1 cycle, code 0.

Source files
------------

// File: rtl/sauria_eoc_pkg.sv
// Shared types and helpers for the SAURIA end-of-computation monitor.
// The monitor waits on several completion mailboxes and reports one verdict.
package sauria_eoc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } eoc_state_e;

  localparam int EocMaxCodeWidth = 64;
  localparam logic [EocMaxCodeWidth-1:0] EocTimeoutCode = '1;

  // Mailbox word layout: bit0 is the EOC flag, the upper bits carry the exit code.
  function automatic logic [EocMaxCodeWidth-1:0] eoc_extract_code(
    input logic [EocMaxCodeWidth-1:0] word
  );
    return word >> 1;
  endfunction

endpackage

// File: rtl/sauria_eoc_watchdog.sv
// Watchdog for the EOC monitor: counts down while running and reloads on heartbeat.
// A reload value of zero keeps the counter at zero, so it never expires.
module sauria_eoc_watchdog #(
  parameter int TimeoutWidth = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    load_i,
  input  logic [TimeoutWidth-1:0] load_val_i,
  input  logic                    run_i,
  input  logic                    reload_i,
  output logic                    expire_o
);

  logic [TimeoutWidth-1:0] cnt_q, cnt_d;
  logic [TimeoutWidth-1:0] rld_q, rld_d;

  always_comb begin
    cnt_d = cnt_q;
    rld_d = rld_q;
    if (load_i) begin
      cnt_d = load_val_i;
      rld_d = load_val_i;
    end else if (run_i) begin
      if (reload_i) begin
        cnt_d = rld_q;
      end else if (cnt_q != '0) begin
        cnt_d = cnt_q - TimeoutWidth'(1);
      end
    end
  end

  assign expire_o = run_i & ~reload_i & (cnt_q == TimeoutWidth'(1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      rld_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      rld_q <= rld_d;
    end
  end

endmodule

// File: rtl/sauria_eoc_monitor.sv
// Multi-channel end-of-computation monitor: collects per-channel EOC words,
// runs a heartbeat watchdog and aggregates one registered done/exit-code verdict.
module sauria_eoc_monitor
  import sauria_eoc_pkg::*;
#(
  parameter int NumChannels  = 4,
  parameter int CodeWidth    = 32,
  parameter int TimeoutWidth = 32,
  parameter int IdxWidth     = (NumChannels > 1) ? $clog2(NumChannels) : 1
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             arm_i,
  input  logic [NumChannels-1:0]           chan_en_i,
  input  logic [TimeoutWidth-1:0]          timeout_cycles_i,
  input  logic [NumChannels-1:0]           wr_valid_i,
  input  logic [NumChannels*CodeWidth-1:0] wr_data_i,
  output logic [NumChannels-1:0]           wr_ready_o,
  output logic                             busy_o,
  output logic                             done_o,
  output logic                             timeout_o,
  output logic [CodeWidth-1:0]             exit_code_o,
  output logic [IdxWidth-1:0]              fail_idx_o,
  output logic [NumChannels-1:0]           chan_done_o
);

  eoc_state_e              state_q, state_d;
  logic [NumChannels-1:0]  en_q, en_d;
  logic [NumChannels-1:0]  chan_done_q, chan_done_d;
  logic [CodeWidth-1:0]    code_q [NumChannels];
  logic [CodeWidth-1:0]    code_d [NumChannels];
  logic [CodeWidth-1:0]    exit_code_q, exit_code_d;
  logic [IdxWidth-1:0]     fail_idx_q, fail_idx_d;
  logic                    timeout_q, timeout_d;

  logic [NumChannels-1:0]  ready, xfer, hb;
  logic                    arm_ok, running, all_done, expire;
  logic [CodeWidth-1:0]    sel_code;
  logic [IdxWidth-1:0]     sel_idx;

  assign running = (state_q == RUN);
  assign arm_ok  = arm_i & (state_q != RUN);
  assign ready   = running ? (en_q & ~chan_done_q) : '0;
  assign xfer    = wr_valid_i & ready;

  always_comb begin
    chan_done_d = chan_done_q;
    hb          = '0;
    for (int i = 0; i < NumChannels; i++) begin
      code_d[i] = code_q[i];
      if (xfer[i]) begin
        if (wr_data_i[i*CodeWidth]) begin
          chan_done_d[i] = 1'b1;
          code_d[i] = CodeWidth'(eoc_extract_code(
                        EocMaxCodeWidth'(wr_data_i[i*CodeWidth +: CodeWidth])));
        end else begin
          hb[i] = 1'b1;
        end
      end
    end
  end

  assign all_done = ((chan_done_d & en_q) == en_q);

  // Scan high-to-low so the lowest enabled channel with a nonzero code wins.
  always_comb begin
    sel_code = '0;
    sel_idx  = '0;
    for (int i = NumChannels - 1; i >= 0; i--) begin
      if (en_q[i] && (code_d[i] != '0)) begin
        sel_code = code_d[i];
        sel_idx  = IdxWidth'(i);
      end
    end
  end

  sauria_eoc_watchdog #(
    .TimeoutWidth (TimeoutWidth)
  ) u_watchdog (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (arm_ok),
    .load_val_i (timeout_cycles_i),
    .run_i      (running),
    .reload_i   (|hb),
    .expire_o   (expire)
  );

  always_comb begin
    state_d     = state_q;
    en_d        = en_q;
    exit_code_d = exit_code_q;
    fail_idx_d  = fail_idx_q;
    timeout_d   = timeout_q;
    if (arm_ok) begin
      en_d        = chan_en_i;
      exit_code_d = '0;
      fail_idx_d  = '0;
      timeout_d   = 1'b0;
      state_d     = (chan_en_i == '0) ? DONE : RUN;
    end else if (running) begin
      // Completion takes precedence over a watchdog expiry in the same cycle.
      if (all_done) begin
        state_d     = DONE;
        exit_code_d = sel_code;
        fail_idx_d  = sel_idx;
      end else if (expire) begin
        state_d     = DONE;
        exit_code_d = EocTimeoutCode[CodeWidth-1:0];
        timeout_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      en_q        <= '0;
      chan_done_q <= '0;
      exit_code_q <= '0;
      fail_idx_q  <= '0;
      timeout_q   <= 1'b0;
      for (int i = 0; i < NumChannels; i++) code_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      en_q        <= en_d;
      exit_code_q <= exit_code_d;
      fail_idx_q  <= fail_idx_d;
      timeout_q   <= timeout_d;
      if (arm_ok) begin
        chan_done_q <= '0;
        for (int i = 0; i < NumChannels; i++) code_q[i] <= '0;
      end else begin
        chan_done_q <= chan_done_d;
        for (int i = 0; i < NumChannels; i++) code_q[i] <= code_d[i];
      end
    end
  end

  assign wr_ready_o  = ready;
  assign busy_o      = running;
  assign done_o      = (state_q == DONE);
  assign timeout_o   = timeout_q;
  assign exit_code_o = exit_code_q;
  assign fail_idx_o  = fail_idx_q;
  assign chan_done_o = chan_done_q;

endmodule
